// File: rtl/pair_scan_ctrl.sv
// pair_scan_ctrl: walks every operand pair (j<k) of data memory, feeds an external distance unit, writes min/max back.
// Latency: 2(N-1) + 2N(N-1) + 2 (mode 0) or 4 (mode 1) write cycles + 1 from launch to done; no backpressure.

module pair_scan_ctrl #(
   parameter int N_OPS    = 32,
   parameter int RES_BASE = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   output logic        done,
   output logic [7:0]  mem_addr,
   output logic        mem_rd_en,
   input  logic [7:0]  mem_rdata,
   output logic        mem_wr_en,
   output logic [7:0]  mem_wdata,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic        op_valid,
   input  logic [15:0] dist_in
);

   localparam logic [5:0] K_LAST   = 6'(N_OPS - 1);
   localparam logic [5:0] J_LAST   = 6'(N_OPS - 2);
   localparam logic [7:0] RES_ADDR = 8'(RES_BASE);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RA_H,
      S_RA_L,
      S_RB_H,
      S_RB_L,
      S_CAP,
      S_EVAL,
      S_WR,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        start_q, start_d;
   logic        mode_q, mode_d;
   logic [5:0]  j_q, j_d;
   logic [5:0]  k_q, k_d;
   logic [15:0] min_q, min_d;
   logic [15:0] max_q, max_d;
   logic [15:0] op_a_q, op_a_d;
   logic [15:0] op_b_q, op_b_d;
   logic        a_lo_pend_q, a_lo_pend_d;
   logic [1:0]  wr_cnt_q, wr_cnt_d;

   logic [15:0] dist_eff;
   logic        busy;
   logic        wr_last;

   assign dist_eff = mode_q ? dist_in : {8'h00, dist_in[7:0]};
   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign wr_last  = mode_q ? (wr_cnt_q == 2'd3) : (wr_cnt_q == 2'd1);

   assign op_a = op_a_q;
   assign op_b = op_b_q;

   always_comb begin
      state_d     = state_q;
      start_d     = start;
      mode_d      = mode_q;
      j_d         = j_q;
      k_d         = k_q;
      min_d       = min_q;
      max_d       = max_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      a_lo_pend_d = a_lo_pend_q;
      wr_cnt_d    = wr_cnt_q;
      mem_addr    = 8'h00;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wdata   = 8'h00;
      op_valid    = 1'b0;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_q && !start) begin
               mode_d      = mode;
               j_d         = 6'd0;
               k_d         = 6'd1;
               min_d       = 16'hFFFF;
               max_d       = 16'h0000;
               a_lo_pend_d = 1'b0;
               wr_cnt_d    = 2'd0;
               state_d     = S_RA_H;
            end
         end
         S_RA_H: begin
            mem_rd_en = 1'b1;
            mem_addr  = {1'b0, j_q, 1'b0};
            state_d   = S_RA_L;
         end
         S_RA_L: begin
            op_a_d[15:8] = mem_rdata;
            mem_rd_en    = 1'b1;
            mem_addr     = {1'b0, j_q, 1'b1};
            a_lo_pend_d  = 1'b1;
            state_d      = S_RB_H;
         end
         S_RB_H: begin
            // op_a low byte only arrives here right after a fresh RA_L read
            if (a_lo_pend_q) begin
               op_a_d[7:0] = mem_rdata;
            end
            a_lo_pend_d = 1'b0;
            mem_rd_en   = 1'b1;
            mem_addr    = {1'b0, k_q, 1'b0};
            state_d     = S_RB_L;
         end
         S_RB_L: begin
            op_b_d[15:8] = mem_rdata;
            mem_rd_en    = 1'b1;
            mem_addr     = {1'b0, k_q, 1'b1};
            state_d      = S_CAP;
         end
         S_CAP: begin
            op_b_d[7:0] = mem_rdata;
            state_d     = S_EVAL;
         end
         S_EVAL: begin
            op_valid = 1'b1;
            if (dist_eff < min_q) begin
               min_d = dist_eff;
            end
            if (dist_eff > max_q) begin
               max_d = dist_eff;
            end
            if (k_q < K_LAST) begin
               k_d     = k_q + 6'd1;
               state_d = S_RB_H;
            end else if (j_q < J_LAST) begin
               j_d     = j_q + 6'd1;
               k_d     = j_q + 6'd2;
               state_d = S_RA_H;
            end else begin
               wr_cnt_d = 2'd0;
               state_d  = S_WR;
            end
         end
         S_WR: begin
            mem_wr_en = 1'b1;
            if (mode_q) begin
               mem_addr = RES_ADDR + 8'd2 + {6'd0, wr_cnt_q};
               case (wr_cnt_q)
                  2'd0:    mem_wdata = min_q[15:8];
                  2'd1:    mem_wdata = min_q[7:0];
                  2'd2:    mem_wdata = max_q[15:8];
                  default: mem_wdata = max_q[7:0];
               endcase
            end else begin
               mem_addr  = RES_ADDR + {6'd0, wr_cnt_q};
               mem_wdata = wr_cnt_q[0] ? max_q[7:0] : min_q[7:0];
            end
            if (wr_last) begin
               wr_cnt_d = 2'd0;
               state_d  = S_DONE;
            end else begin
               wr_cnt_d = wr_cnt_q + 2'd1;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything, including a result byte due this cycle
      if (busy && start) begin
         state_d     = S_IDLE;
         wr_cnt_d    = 2'd0;
         a_lo_pend_d = 1'b0;
         mem_addr    = 8'h00;
         mem_rd_en   = 1'b0;
         mem_wr_en   = 1'b0;
         mem_wdata   = 8'h00;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         mode_q      <= 1'b0;
         j_q         <= 6'd0;
         k_q         <= 6'd0;
         min_q       <= 16'hFFFF;
         max_q       <= 16'h0000;
         op_a_q      <= 16'h0000;
         op_b_q      <= 16'h0000;
         a_lo_pend_q <= 1'b0;
         wr_cnt_q    <= 2'd0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         mode_q      <= mode_d;
         j_q         <= j_d;
         k_q         <= k_d;
         min_q       <= min_d;
         max_q       <= max_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         a_lo_pend_q <= a_lo_pend_d;
         wr_cnt_q    <= wr_cnt_d;
      end
   end

   a_rd_wr_excl : assert property (@(posedge clk) disable iff (reset)
      !(mem_rd_en && mem_wr_en));

   a_addr_idle : assert property (@(posedge clk) disable iff (reset)
      (!mem_rd_en && !mem_wr_en) |-> (mem_addr == 8'h00));

endmodule
